// File: rtl/seven_segment_capture.sv
// Receive-side monitor for a multiplexed seven-segment display: synchronizes the
// active-low digit enables and segments, waits for the bus to settle, then decodes
// and stores one value per digit, pulsing frame_valid once every digit has been seen.
// Output latency: a pin change held constant updates the outputs on the
// SETTLE_CYCLES+3 rising edge after the change.
module seven_segment_capture #(
   parameter int NUM_DIGITS    = 4,
   parameter int HEX           = 0,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_DIGITS-1:0]   enable_in,
   input  logic [7:0]              led_in,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   dp_out,
   output logic [NUM_DIGITS-1:0]   digit_err,
   output logic                    frame_valid
);

   localparam int W  = NUM_DIGITS + 8;
   localparam int CW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]         CNT_ZERO = CW'(0);
   localparam logic [CW-1:0]         CNT_MAX  = CW'(SETTLE_CYCLES);
   localparam logic [CW-1:0]         CNT_PRE  = CW'(SETTLE_CYCLES - 1);
   localparam logic [NUM_DIGITS-1:0] D_ZERO   = {NUM_DIGITS{1'b0}};
   localparam logic [NUM_DIGITS-1:0] D_ONES   = {NUM_DIGITS{1'b1}};
   localparam logic [NUM_DIGITS-1:0] D_ONE    = NUM_DIGITS'(1);

   // Returns {valid, value}; segment order a..g, active-low.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      r = 5'b0_0000;
      case (seg)
         7'b0000001: r = {1'b1, 4'h0};
         7'b1001111: r = {1'b1, 4'h1};
         7'b0010010: r = {1'b1, 4'h2};
         7'b0000110: r = {1'b1, 4'h3};
         7'b1001100: r = {1'b1, 4'h4};
         7'b0100100: r = {1'b1, 4'h5};
         7'b0100000: r = {1'b1, 4'h6};
         7'b0001111: r = {1'b1, 4'h7};
         7'b0000000: r = {1'b1, 4'h8};
         7'b0000100: r = {1'b1, 4'h9};
         7'b0001000: r = (HEX != 0) ? {1'b1, 4'hA} : 5'b0_0000;
         7'b1100000: r = (HEX != 0) ? {1'b1, 4'hB} : 5'b0_0000;
         7'b0110001: r = (HEX != 0) ? {1'b1, 4'hC} : 5'b0_0000;
         7'b1000010: r = (HEX != 0) ? {1'b1, 4'hD} : 5'b0_0000;
         7'b0110000: r = (HEX != 0) ? {1'b1, 4'hE} : 5'b0_0000;
         7'b0111000: r = (HEX != 0) ? {1'b1, 4'hF} : 5'b0_0000;
         default:    r = 5'b0_0000;
      endcase
      return r;
   endfunction

   logic [NUM_DIGITS-1:0] en_meta_r, en_sync_r;
   logic [7:0]            led_meta_r, led_sync_r;
   logic [W-1:0]          prev_r;
   logic [CW-1:0]         cnt_r;
   logic [NUM_DIGITS-1:0] seen_r;

   logic [W-1:0]          sample_s;
   logic                  match_s;
   logic                  capture_s;
   logic [NUM_DIGITS-1:0] low_s;
   logic                  single_s;
   logic [4:0]            dec_s;
   logic [NUM_DIGITS-1:0] seen_next_s;

   // Settle detection, one-hot-low check and decode of the synchronized word.
   always_comb begin
      sample_s    = {en_sync_r, led_sync_r};
      match_s     = (sample_s == prev_r);
      capture_s   = match_s && (cnt_r == CNT_PRE);
      low_s       = ~en_sync_r;
      single_s    = (low_s != D_ZERO) && ((low_s & (low_s - D_ONE)) == D_ZERO);
      dec_s       = decode_seg(led_sync_r[7:1]);
      seen_next_s = seen_r | low_s;
   end

   // Two-flop synchronizers; reset to the inactive (all-ones) bus level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_meta_r  <= D_ONES;
         en_sync_r  <= D_ONES;
         led_meta_r <= 8'hFF;
         led_sync_r <= 8'hFF;
      end else begin
         en_meta_r  <= enable_in;
         en_sync_r  <= en_meta_r;
         led_meta_r <= led_in;
         led_sync_r <= led_meta_r;
      end
   end

   // Stability counter, capture into the digit slots and frame tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_r      <= {W{1'b1}};
         cnt_r       <= CNT_ZERO;
         seen_r      <= D_ZERO;
         digits_out  <= {(4*NUM_DIGITS){1'b0}};
         dp_out      <= D_ZERO;
         digit_err   <= D_ZERO;
         frame_valid <= 1'b0;
      end else begin
         prev_r      <= sample_s;
         frame_valid <= 1'b0;
         if (!match_s) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (capture_s && single_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (low_s[i]) begin
                  dp_out[i]    <= ~led_sync_r[0];
                  digit_err[i] <= ~dec_s[4];
                  if (dec_s[4]) begin
                     digits_out[4*i +: 4] <= dec_s[3:0];
                  end
               end
            end
            // A completing capture pulses and restarts the mask in the same edge.
            if (seen_next_s == D_ONES) begin
               frame_valid <= 1'b1;
               seen_r      <= D_ZERO;
            end else begin
               seen_r <= seen_next_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: a HEX=0 and a HEX=1 instance share
// the same pins; expected captures are queued on drive and compared after settling.
module tb_seven_segment_capture;

   localparam int ND = 4;
   localparam int SC = 16;

   // Active-low a..g patterns for values 0..F.
   localparam logic [6:0] PAT [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct {
      int         slot;
      logic [3:0] val;
      logic       dp;
      logic       err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [ND-1:0] enable_in = 4'b1111;
   logic [7:0]    led_in = 8'hFF;
   logic [15:0]   digits_out, digits_hex;
   logic [ND-1:0] dp_out, dp_hex, err, err_hex;
   logic          fv, fv_hex;

   int checks = 0;
   int failures = 0;
   int fv_count = 0, fv_run = 0, fv_maxw = 0, upd_count = 0;
   logic [23:0] last_obs = 24'h0;

   exp_t       exp_q[$];
   logic [3:0] m_val [ND];
   logic [3:0] m_dp, m_err;

   always #5 clk = ~clk;

   seven_segment_capture #(.NUM_DIGITS(ND), .HEX(0), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .enable_in(enable_in), .led_in(led_in),
      .digits_out(digits_out), .dp_out(dp_out), .digit_err(err), .frame_valid(fv));

   seven_segment_capture #(.NUM_DIGITS(ND), .HEX(1), .SETTLE_CYCLES(SC)) dut_hex (
      .clk(clk), .rst(rst), .enable_in(enable_in), .led_in(led_in),
      .digits_out(digits_hex), .dp_out(dp_hex), .digit_err(err_hex), .frame_valid(fv_hex));

   // Pulse counting / width tracking and output-change counting for the HEX=0 instance.
   always @(negedge clk) begin
      if (fv) begin
         if (fv_run == 0) fv_count <= fv_count + 1;
         fv_run <= fv_run + 1;
         if (fv_run + 1 > fv_maxw) fv_maxw <= fv_run + 1;
      end else begin
         fv_run <= 0;
      end
      if (!rst && ({digits_out, dp_out, err} !== last_obs)) upd_count <= upd_count + 1;
      last_obs <= {digits_out, dp_out, err};
   end

   function automatic logic [4:0] ref_decode(input logic [6:0] p, input bit hex);
      logic [4:0] r;
      r = 5'b0_0000;
      for (int v = 0; v < 16; v++) begin
         if (PAT[v] == p && (v < 10 || hex)) r = {1'b1, 4'(v)};
      end
      return r;
   endfunction

   task automatic clear_model();
      for (int k = 0; k < ND; k++) m_val[k] = 4'h0;
      m_dp  = 4'h0;
      m_err = 4'h0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      enable_in = 4'b1111;
      led_in = 8'hFF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
   endtask

   task automatic push_expected(input int slot, input logic [7:0] led);
      exp_t e;
      logic [4:0] d;
      d = ref_decode(led[7:1], 1'b0);
      m_dp[slot]  = ~led[0];
      m_err[slot] = ~d[4];
      if (d[4]) m_val[slot] = d[3:0];
      e.slot = slot;
      e.val  = m_val[slot];
      e.dp   = m_dp[slot];
      e.err  = m_err[slot];
      exp_q.push_back(e);
   endtask

   task automatic pop_compare(input string name);
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (digits_out[4*e.slot +: 4] !== e.val) begin
         failures++;
         $display("FAIL %s slot%0d value: got %h expected %h", name, e.slot, digits_out[4*e.slot +: 4], e.val);
      end
      checks++;
      if (dp_out[e.slot] !== e.dp) begin
         failures++;
         $display("FAIL %s dp%0d: got %b expected %b", name, e.slot, dp_out[e.slot], e.dp);
      end
      checks++;
      if (err[e.slot] !== e.err) begin
         failures++;
         $display("FAIL %s err%0d: got %b expected %b", name, e.slot, err[e.slot], e.err);
      end
   endtask

   task automatic drive_digit(input int slot, input logic [7:0] led, input string name);
      @(negedge clk);
      enable_in = 4'b1111;
      enable_in[slot] = 1'b0;
      led_in = led;
      push_expected(slot, led);
      repeat (32) @(negedge clk);
      pop_compare(name);
      enable_in = 4'b1111;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset();
      int fb;
      checks++;
      if ({digits_out, dp_out, err, fv} !== 25'h0) begin
         failures++;
         $display("FAIL reset_values: got %h expected 0", {digits_out, dp_out, err, fv});
      end
      do_reset();
      fb = fv_count;
      repeat (30) @(negedge clk);
      checks++;
      if ({digits_out, dp_out, err} !== 24'h0 || fv_count != fb) begin
         failures++;
         $display("FAIL reset_idle: outputs %h pulses %0d expected 0/0", {digits_out, dp_out, err}, fv_count - fb);
      end
   endtask

   task automatic test_single_capture();
      int k, ub, fb;
      do_reset();
      ub = upd_count;
      fb = fv_count;
      @(negedge clk);
      enable_in = 4'b1110;
      led_in = 8'b00100101;
      push_expected(0, 8'b00100101);
      k = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (digits_out[3:0] == 4'h2) begin
            k = n;
            break;
         end
      end
      checks++;
      if (k < SC + 2 || k > SC + 4) begin
         failures++;
         $display("FAIL latency: got %0d edges expected %0d..%0d", k, SC + 2, SC + 4);
      end
      repeat (40 - ((k > 0) ? k : 40)) @(negedge clk);
      @(negedge clk);
      pop_compare("single");
      checks++;
      if (upd_count - ub != 1 || fv_count != fb) begin
         failures++;
         $display("FAIL single_updates: got upd=%0d pulses=%0d expected 1/0", upd_count - ub, fv_count - fb);
      end
   endtask

   task automatic test_scan();
      logic [7:0] leds [4] = '{8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001};
      int fb;
      do_reset();
      fb = fv_count;
      for (int s = 0; s < 2; s++) begin
         for (int d = 0; d < 3; d++) drive_digit(d, leds[d], "scan");
         checks++;
         if (fv_count - fb != s) begin
            failures++;
            $display("FAIL scan_early_pulse: got %0d expected %0d", fv_count - fb, s);
         end
         drive_digit(3, leds[3], "scan");
         checks++;
         if (fv_count - fb != s + 1) begin
            failures++;
            $display("FAIL scan_pulse: got %0d expected %0d", fv_count - fb, s + 1);
         end
      end
      checks++;
      if (digits_out !== 16'h4321) begin
         failures++;
         $display("FAIL scan_digits: got %h expected 4321", digits_out);
      end
      checks++;
      if (fv_maxw != 1) begin
         failures++;
         $display("FAIL pulse_width: got %0d expected 1", fv_maxw);
      end
   endtask

   task automatic test_unstable();
      int ub;
      do_reset();
      ub = upd_count;
      enable_in = 4'b1110;
      for (int t = 0; t < 12; t++) begin
         led_in = t[0] ? 8'b10011111 : 8'b00000001;
         repeat (5) @(negedge clk);
      end
      checks++;
      if (upd_count != ub || digits_out !== 16'h0) begin
         failures++;
         $display("FAIL unstable: got upd=%0d digits=%h expected 0/0000", upd_count - ub, digits_out);
      end
      drive_digit(0, 8'b00011110, "settle7");
   endtask

   task automatic test_hex();
      do_reset();
      drive_digit(1, 8'b01001001, "hex_pre5");
      drive_digit(1, 8'b00010001, "hex0_A");
      checks++;
      if (digits_hex[7:4] !== 4'hA || err_hex[1] !== 1'b0) begin
         failures++;
         $display("FAIL hex1_A: got %h err %b expected a err 0", digits_hex[7:4], err_hex[1]);
      end
   endtask

   task automatic test_two_low();
      int ub, fb;
      do_reset();
      drive_digit(0, 8'b00100101, "twolow_pre");
      ub = upd_count;
      fb = fv_count;
      enable_in = 4'b1100;
      led_in = 8'b00000011;
      repeat (40) @(negedge clk);
      enable_in = 4'b1111;
      repeat (8) @(negedge clk);
      checks++;
      if (upd_count != ub || fv_count != fb) begin
         failures++;
         $display("FAIL two_low: got upd=%0d pulses=%0d expected 0/0", upd_count - ub, fv_count - fb);
      end
      drive_digit(1, 8'b10011111, "twolow");
      drive_digit(2, 8'b00001101, "twolow");
      checks++;
      if (fv_count != fb) begin
         failures++;
         $display("FAIL two_low_mask: got %0d pulses expected 0", fv_count - fb);
      end
      drive_digit(3, 8'b10011001, "twolow");
      checks++;
      if (fv_count - fb != 1) begin
         failures++;
         $display("FAIL two_low_frame: got %0d pulses expected 1", fv_count - fb);
      end
   endtask

   task automatic test_async_reset();
      int fb;
      do_reset();
      drive_digit(0, 8'b00000011, "arst_pre");
      drive_digit(1, 8'b10011111, "arst_pre");
      drive_digit(2, 8'b00100101, "arst_pre");
      @(posedge clk);
      #3;
      rst = 1'b1;
      enable_in = 4'b1111;
      led_in = 8'hFF;
      #1;
      checks++;
      if ({digits_out, dp_out, err, fv} !== 25'h0) begin
         failures++;
         $display("FAIL async_reset: got %h expected 0", {digits_out, dp_out, err, fv});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      fb = fv_count;
      drive_digit(3, 8'b10011001, "arst_post");
      drive_digit(0, 8'b00000011, "arst_post");
      drive_digit(1, 8'b10011111, "arst_post");
      checks++;
      if (fv_count != fb) begin
         failures++;
         $display("FAIL async_partial: got %0d pulses expected 0", fv_count - fb);
      end
      drive_digit(2, 8'b00100101, "arst_post");
      checks++;
      if (fv_count - fb != 1) begin
         failures++;
         $display("FAIL async_full: got %0d pulses expected 1", fv_count - fb);
      end
   endtask

   initial begin
      clear_model();
      #2;
      test_reset();
      test_single_capture();
      test_scan();
      test_unstable();
      test_hex();
      test_two_low();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
